// File: rtl/pipe_skid_buffer_pkg.sv
// rtl/pipe_skid_buffer_pkg.sv - shared SM4 constants and skid-buffer occupancy encoding
package pipe_skid_buffer_pkg;

    localparam int SM4_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry skid buffer that turns downstream backpressure into a registered upstream stall
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int WIDTH = SM4_BLOCK_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_stall;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_xfer;

    assign w_accept = in_valid && !r_stall;
    assign w_xfer   = out_valid && out_ready;

    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign stall     = r_stall;
    assign stall_cnt = r_cnt;

    // stall is set/cleared alongside the FULL transitions so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_stall <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_xfer) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid  <= in_data;
                        r_state <= ST_FULL;
                        r_stall <= 1'b1;
                    end else if (w_xfer) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_xfer) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_stall <= 1'b0;
                end
            endcase

            if (r_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, the data word width in bits (one SM4 block).
REQ-002 The block SHALL have parameter CNT_W, default 16, the stall-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream pipeline's last stage holds a valid word.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the upstream word.
REQ-007 The block SHALL have port stall, output, 1 bit: hold request fanned to every upstream pipeline register.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the downstream word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word this cycle.
REQ-011 The block SHALL have port stall_cnt, output, CNT_W bits: saturating count of cycles with stall=1.

Function
REQ-012 The block SHALL have three occupancy states: EMPTY (0 words), ONE (main register holds a word), FULL (main and skid registers both hold words).
REQ-013 stall SHALL be a registered output equal to 1 exactly when the state is FULL; it SHALL have no combinational path from out_ready.
REQ-014 An upstream word SHALL be accepted in a cycle when in_valid=1 and stall=0; when stall=1, in_data SHALL be ignored, because upstream is holding it.
REQ-015 A downstream transfer SHALL occur in a cycle when out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY; out_data SHALL be the main register.
REQ-017 Transitions from EMPTY: accept leads to ONE with main=in_data; otherwise the state stays EMPTY.
REQ-018 Transitions from ONE:
- accept and transfer: stay ONE, main=in_data.
- accept only: go to FULL, skid=in_data.
- transfer only: go to EMPTY.
- neither: hold.
REQ-019 Transitions from FULL:
- transfer: go to ONE, main=skid.
- no transfer: hold (no accept is possible).
REQ-020 Latency SHALL be one cycle: a word accepted in cycle N SHALL appear on out_data in cycle N+1 when the buffer was EMPTY, or when it was ONE and that cycle transferred.
REQ-021 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 stall_cnt SHALL increment by 1 each cycle that stall=1 and SHALL saturate at all-ones; it SHALL NOT wrap.
REQ-024 With out_ready held at 1, the buffer SHALL sustain one word per cycle and stall SHALL never assert.

Reset
REQ-025 While rst_n=0 the block SHALL be in EMPTY with stall=0, out_valid=0, out_data=0, skid register=0 and stall_cnt=0.
REQ-026 Reset mid-operation SHALL discard both buffered words immediately; accepting starts on the first clock edge after rst_n deasserts.

Structure
REQ-027 The state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the SM4 block width constant (128) SHALL reside in the shared SM4 package/include file.
REQ-028 The block SHALL be a single module with no sub-modules; the main and skid registers SHALL be plain enable-loaded registers inside it.

Verification
REQ-029 Streaming: in_valid=1 with words 0x1..0x8 and out_ready=1 throughout -> out_data shows 0x1..0x8 on consecutive cycles, one cycle after input, and stall stays 0.
REQ-030 Backpressure: send 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, stall=1 from the cycle after 0xB is accepted, 0xC held upstream. Then raise out_ready -> outputs 0xA, 0xB, 0xC in order, and stall drops the cycle after 0xA transfers.
REQ-031 Hold stability: out_ready=0 for 5 cycles while FULL -> out_data constant, stall_cnt increments by 5.
REQ-032 Saturation: with CNT_W=4, hold FULL for 20 cycles -> stall_cnt reaches 4'hF and stays there.
REQ-033 Reset mid-operation: assert rst_n=0 while FULL -> out_valid=0, stall=0 and stall_cnt=0 immediately; after release the first word accepted is the first word output.
REQ-034 Random: random in_valid/out_ready at 50% for 10k cycles against a reference queue model -> order preserved, no loss or duplication, and stall asserted only when two words are held.
